usb_epp_fifo_bridge: RTL and testbench

//  Parametrised EPP (Digilent USB) slave bridging the host to the machine through two byte FIFOs.

---
 rtl/usb_epp_fifo_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_usb_epp_fifo_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_epp_fifo_bridge.sv
// Digilent EPP slave: host writes feed the h2m FIFO, host reads drain the m2h FIFO, plus status/control/fill registers.
// Optional build macro USB_EPP_STALL_EN: hold usb_wait low on full/empty FIFO access instead of dropping with a sticky flag.
module usb_epp_fifo_bridge #(
    parameter int H2M_DEPTH   = 16,
    parameter int M2H_DEPTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_write,
    input  logic       usb_astb,
    input  logic       usb_dstb,
    inout  wire  [7:0] usb_db,
    output logic       usb_wait,
    output logic [7:0] h2m_data,
    output logic       h2m_valid,
    input  logic       h2m_ready,
    input  logic [7:0] m2h_data,
    input  logic       m2h_valid,
    output logic       m2h_ready
);
    localparam int HAW = $clog2(H2M_DEPTH);
    localparam int MAW = $clog2(M2H_DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] astb_sync_q, astb_sync_d;
    logic [SYNC_STAGES-1:0] dstb_sync_q, dstb_sync_d;
    logic [SYNC_STAGES-1:0] write_sync_q, write_sync_d;
    logic                   wait_q, wait_d;
    logic                   drive_q, drive_d;
    logic [7:0]             dout_q, dout_d;
    logic [7:0]             addr_q, addr_d;
    logic                   is_addr_q, is_addr_d;
    logic                   rd_q, rd_d;
    logic [7:0]             byte_q, byte_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic [HAW-1:0]         h2m_wr_q, h2m_wr_d, h2m_rd_q, h2m_rd_d;
    logic [HAW:0]           h2m_cnt_q, h2m_cnt_d;
    logic [MAW-1:0]         m2h_wr_q, m2h_wr_d, m2h_rd_q, m2h_rd_d;
    logic [MAW:0]           m2h_cnt_q, m2h_cnt_d;

    logic [7:0] h2m_mem [H2M_DEPTH];
    logic [7:0] m2h_mem [M2H_DEPTH];

    logic astb_s, dstb_s, write_s, strobe, stall;
    logic h2m_full, h2m_empty, m2h_full, m2h_empty;
    logic h2m_pop, m2h_push, host_push, host_pop;
    logic flush_h, flush_m, ovf_set, unf_set, stat_clr;
    logic [7:0] status;

    assign astb_s    = astb_sync_q[SYNC_STAGES-1];
    assign dstb_s    = dstb_sync_q[SYNC_STAGES-1];
    assign write_s   = write_sync_q[SYNC_STAGES-1];
    assign strobe    = !astb_s || !dstb_s;
    assign h2m_full  = h2m_cnt_q == (HAW+1)'(H2M_DEPTH);
    assign h2m_empty = h2m_cnt_q == '0;
    assign m2h_full  = m2h_cnt_q == (MAW+1)'(M2H_DEPTH);
    assign m2h_empty = m2h_cnt_q == '0;
    assign status    = {2'b00, unf_q, ovf_q, m2h_full, m2h_empty, h2m_full, h2m_empty};

    assign h2m_valid = !h2m_empty;
    assign h2m_data  = h2m_mem[h2m_rd_q];
    assign m2h_ready = !m2h_full;
    assign h2m_pop   = h2m_valid && h2m_ready;
    assign m2h_push  = m2h_valid && m2h_ready;
    assign usb_wait  = wait_q;
    assign usb_db    = drive_q ? dout_q : 8'hzz;

    always_comb begin
        astb_sync_d  = {astb_sync_q[SYNC_STAGES-2:0], usb_astb};
        dstb_sync_d  = {dstb_sync_q[SYNC_STAGES-2:0], usb_dstb};
        write_sync_d = {write_sync_q[SYNC_STAGES-2:0], usb_write};
        state_d   = state_q;
        wait_d    = wait_q;
        drive_d   = drive_q;
        dout_d    = dout_q;
        addr_d    = addr_q;
        is_addr_d = is_addr_q;
        rd_d      = rd_q;
        byte_d    = byte_q;
        host_push = 1'b0;
        host_pop  = 1'b0;
        flush_h   = 1'b0;
        flush_m   = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        stat_clr  = 1'b0;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                if (strobe) begin
`ifdef USB_EPP_STALL_EN
                    stall = astb_s && ((!write_s && addr_q == 8'd0 && h2m_full) ||
                                       (write_s && addr_q == 8'd1 && m2h_empty));
`endif
                    if (!stall) begin
                        state_d   = ACK;
                        wait_d    = 1'b1;
                        is_addr_d = !astb_s;
                        rd_d      = write_s;
                        byte_d    = usb_db;
                        if (write_s) begin
                            // Read side effects (pop, sticky clear) happen once, on ACK entry.
                            drive_d = 1'b1;
                            dout_d  = 8'h00;
                            if (!astb_s) begin
                                dout_d = addr_q;
                            end else begin
                                case (addr_q)
                                    8'd1: begin
                                        if (!m2h_empty) begin
                                            dout_d   = m2h_mem[m2h_rd_q];
                                            host_pop = 1'b1;
                                        end else begin
                                            unf_set = 1'b1;
                                        end
                                    end
                                    8'd2: begin
                                        dout_d   = status;
                                        stat_clr = 1'b1;
                                    end
                                    8'd4:    dout_d = 8'(h2m_cnt_q);
                                    8'd5:    dout_d = 8'(m2h_cnt_q);
                                    default: dout_d = 8'h00;
                                endcase
                            end
                        end
                    end
                end
            end
            ACK: begin
                if (!strobe) begin
                    state_d = IDLE;
                    wait_d  = 1'b0;
                    drive_d = 1'b0;
                    if (!rd_q) begin
                        if (is_addr_q) begin
                            addr_d = byte_q;
                        end else if (addr_q == 8'd0) begin
                            if (!h2m_full || h2m_pop) host_push = 1'b1;
                            else                      ovf_set   = 1'b1;
                        end else if (addr_q == 8'd3) begin
                            flush_h = byte_q[0];
                            flush_m = byte_q[1];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ovf_d = (ovf_q && !stat_clr) || ovf_set;
        unf_d = (unf_q && !stat_clr) || unf_set;

        // A flush overrides any machine-side transfer on the same edge.
        if (flush_h) begin
            h2m_wr_d  = '0;
            h2m_rd_d  = '0;
            h2m_cnt_d = '0;
        end else begin
            h2m_wr_d  = h2m_wr_q + HAW'(host_push);
            h2m_rd_d  = h2m_rd_q + HAW'(h2m_pop);
            h2m_cnt_d = h2m_cnt_q + (HAW+1)'(host_push) - (HAW+1)'(h2m_pop);
        end
        if (flush_m) begin
            m2h_wr_d  = '0;
            m2h_rd_d  = '0;
            m2h_cnt_d = '0;
        end else begin
            m2h_wr_d  = m2h_wr_q + MAW'(m2h_push);
            m2h_rd_d  = m2h_rd_q + MAW'(host_pop);
            m2h_cnt_d = m2h_cnt_q + (MAW+1)'(m2h_push) - (MAW+1)'(host_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            astb_sync_q  <= '1;
            dstb_sync_q  <= '1;
            write_sync_q <= '0;
            wait_q       <= 1'b0;
            drive_q      <= 1'b0;
            addr_q       <= 8'h00;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            h2m_wr_q     <= '0;
            h2m_rd_q     <= '0;
            h2m_cnt_q    <= '0;
            m2h_wr_q     <= '0;
            m2h_rd_q     <= '0;
            m2h_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            astb_sync_q  <= astb_sync_d;
            dstb_sync_q  <= dstb_sync_d;
            write_sync_q <= write_sync_d;
            wait_q       <= wait_d;
            drive_q      <= drive_d;
            addr_q       <= addr_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            h2m_wr_q     <= h2m_wr_d;
            h2m_rd_q     <= h2m_rd_d;
            h2m_cnt_q    <= h2m_cnt_d;
            m2h_wr_q     <= m2h_wr_d;
            m2h_rd_q     <= m2h_rd_d;
            m2h_cnt_q    <= m2h_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        dout_q    <= dout_d;
        byte_q    <= byte_d;
        is_addr_q <= is_addr_d;
        rd_q      <= rd_d;
        if (host_push)             h2m_mem[h2m_wr_q] <= byte_q;
        if (m2h_push && !flush_m)  m2h_mem[m2h_wr_q] <= m2h_data;
    end
endmodule

// File: tb/tb_usb_epp_fifo_bridge.sv
// Bench for usb_epp_fifo_bridge: queue-based reference model checked every cycle, directed cases, then random traffic.
module tb_usb_epp_fifo_bridge;
    localparam int HD = 16;
    localparam int MD = 16;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset, usb_write, usb_astb, usb_dstb;
    wire  [7:0] usb_db;
    logic [7:0] tb_db;
    logic       tb_drv;
    logic       usb_wait, h2m_valid, h2m_ready, m2h_valid, m2h_ready;
    logic [7:0] h2m_data, m2h_data;

    logic       rand_en, r_ready, r_valid, d_ready, d_valid;
    logic [7:0] r_data, d_data;

    int n_tests = 0;
    int n_fail  = 0;

    assign usb_db    = tb_drv ? tb_db : 8'hzz;
    assign h2m_ready = rand_en ? r_ready : d_ready;
    assign m2h_valid = rand_en ? r_valid : d_valid;
    assign m2h_data  = rand_en ? r_data  : d_data;

    always #5 clk = ~clk;

    usb_epp_fifo_bridge #(.H2M_DEPTH(HD), .M2H_DEPTH(MD), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .usb_write(usb_write), .usb_astb(usb_astb),
        .usb_dstb(usb_dstb), .usb_db(usb_db), .usb_wait(usb_wait),
        .h2m_data(h2m_data), .h2m_valid(h2m_valid), .h2m_ready(h2m_ready),
        .m2h_data(m2h_data), .m2h_valid(m2h_valid), .m2h_ready(m2h_ready)
    );

    // Reference model: FIFOs as queues, host strobes seen SS edges late.
    byte unsigned q_h[$];
    byte unsigned q_m[$];
    logic [2:0]   hist[$];
    bit           m_live = 1'b0;
    bit           m_busy, m_wait, m_drive, m_is_addr, m_rd, m_ovf, m_unf;
    logic [7:0]   m_dout, m_addr, m_byte;

    always @(posedge clk) begin : model
        logic [2:0] s;
        logic [7:0] st;
        bit sa, sd, sw, pop_h, push_m, hpush, hpop, fl_h, fl_m, ovs, uns, clr, stall;
        if (reset) begin
            q_h.delete();
            q_m.delete();
            hist.delete();
            for (int i = 0; i < SS; i++) hist.push_back(3'b011);
            m_busy = 0; m_wait = 0; m_drive = 0; m_addr = 8'h00; m_ovf = 0; m_unf = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            s = hist.pop_front();
            hist.push_back({usb_write, usb_dstb, usb_astb});
            sa = s[0]; sd = s[1]; sw = s[2];
            st = {2'b00, m_unf, m_ovf, q_m.size() == MD, q_m.size() == 0,
                  q_h.size() == HD, q_h.size() == 0};
            pop_h  = (q_h.size() > 0) && h2m_ready;
            push_m = (q_m.size() < MD) && m2h_valid;
            hpush = 0; hpop = 0; fl_h = 0; fl_m = 0; ovs = 0; uns = 0; clr = 0; stall = 0;
            if (!m_busy) begin
                if (!sa || !sd) begin
`ifdef USB_EPP_STALL_EN
                    stall = sa && ((!sw && m_addr == 8'd0 && q_h.size() == HD) ||
                                   (sw && m_addr == 8'd1 && q_m.size() == 0));
`endif
                    if (!stall) begin
                        m_busy = 1; m_wait = 1; m_is_addr = !sa; m_rd = sw; m_byte = tb_db;
                        if (sw) begin
                            m_drive = 1;
                            m_dout  = 8'h00;
                            if (!sa) m_dout = m_addr;
                            else if (m_addr == 8'd1) begin
                                if (q_m.size() > 0) begin m_dout = q_m[0]; hpop = 1; end
                                else uns = 1;
                            end
                            else if (m_addr == 8'd2) begin m_dout = st; clr = 1; end
                            else if (m_addr == 8'd4) m_dout = 8'(q_h.size());
                            else if (m_addr == 8'd5) m_dout = 8'(q_m.size());
                        end
                    end
                end
            end else if (sa && sd) begin
                m_busy = 0; m_wait = 0; m_drive = 0;
                if (!m_rd) begin
                    if (m_is_addr) m_addr = m_byte;
                    else if (m_addr == 8'd0) begin
                        if (q_h.size() < HD || pop_h) hpush = 1;
                        else ovs = 1;
                    end
                    else if (m_addr == 8'd3) begin fl_h = m_byte[0]; fl_m = m_byte[1]; end
                end
            end
            if (fl_h) q_h.delete();
            else begin
                if (pop_h) void'(q_h.pop_front());
                if (hpush) q_h.push_back(m_byte);
            end
            if (fl_m) q_m.delete();
            else begin
                if (hpop)   void'(q_m.pop_front());
                if (push_m) q_m.push_back(m2h_data);
            end
            m_ovf = (m_ovf && !clr) || ovs;
            m_unf = (m_unf && !clr) || uns;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_wait", {7'b0, usb_wait}, {7'b0, m_wait});
            chk("model_h2m_valid", {7'b0, h2m_valid}, {7'b0, q_h.size() > 0});
            if (q_h.size() > 0) chk("model_h2m_data", h2m_data, q_h[0]);
            chk("model_m2h_ready", {7'b0, m2h_ready}, {7'b0, q_m.size() < MD});
            if (m_drive) chk("model_bus", usb_db, m_dout);
        end
    end

    initial begin
        r_ready = 0; r_valid = 0; r_data = 8'h00;
        forever begin
            @(negedge clk);
            r_ready = 1'($urandom_range(0, 1));
            r_valid = 1'($urandom_range(0, 1));
            r_data  = 8'($urandom);
        end
    end

    task automatic wait_for(input logic lvl, input string nm);
        int t = 0;
        while (usb_wait !== lvl && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL %s: usb_wait stayed %b, expected %b", nm, usb_wait, lvl);
        end
    endtask

    task automatic host(input bit is_addr, input bit rd, input logic [7:0] wd, output logic [7:0] rdv);
        usb_write = rd;
        tb_drv    = !rd;
        tb_db     = wd;
        repeat (SS + 1) @(negedge clk);
        if (is_addr) usb_astb = 1'b0;
        else         usb_dstb = 1'b0;
        wait_for(1'b1, "wait_rise");
        rdv = usb_db;
        usb_astb = 1'b1;
        usb_dstb = 1'b1;
        wait_for(1'b0, "wait_fall");
        @(negedge clk);
    endtask

    task automatic aw(input logic [7:0] a);
        logic [7:0] v;
        host(1, 0, a, v);
    endtask

    task automatic dw(input logic [7:0] d);
        logic [7:0] v;
        host(0, 0, d, v);
    endtask

    task automatic dr_chk(input string nm, input logic [7:0] exp);
        logic [7:0] v;
        host(0, 1, 8'h00, v);
        chk(nm, v, exp);
    endtask

    task automatic mpush(input logic [7:0] d);
        d_valid = 1'b1;
        d_data  = d;
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    task automatic mpop_chk(input logic [7:0] exp);
        chk("h2m_head", h2m_data, exp);
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int t;
        reset = 1; usb_write = 0; usb_astb = 1; usb_dstb = 1; tb_drv = 1; tb_db = 8'h00;
        rand_en = 0; d_ready = 0; d_valid = 0; d_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_wait", {7'b0, usb_wait}, 8'h00);
        chk("rst_h2m_valid", {7'b0, h2m_valid}, 8'h00);
        chk("rst_m2h_ready", {7'b0, m2h_ready}, 8'h01);
        reset = 0;
        @(negedge clk);

        aw(8'h00);
        dw(8'h11); dw(8'h22); dw(8'h33);
        chk("h2m_valid_after_writes", {7'b0, h2m_valid}, 8'h01);
        aw(8'h04);
        dr_chk("h2m_count3", 8'h03);
        mpop_chk(8'h11);
        dr_chk("h2m_count2", 8'h02);
        mpop_chk(8'h22);
        dr_chk("h2m_count1", 8'h01);
        mpop_chk(8'h33);
        dr_chk("h2m_count0", 8'h00);

        mpush(8'hA5);
        mpush(8'h5A);
        aw(8'h01);
        dr_chk("m2h_read_a5", 8'hA5);
        dr_chk("m2h_read_5a", 8'h5A);
        aw(8'h05);
        dr_chk("m2h_count0", 8'h00);
        chk("m2h_ready_empty", {7'b0, m2h_ready}, 8'h01);

`ifdef USB_EPP_STALL_EN
        aw(8'h01);
        usb_write = 1; tb_drv = 0;
        repeat (SS + 1) @(negedge clk);
        usb_dstb = 0;
        repeat (8) @(negedge clk);
        chk("stall_wait_low", {7'b0, usb_wait}, 8'h00);
        mpush(8'h7E);
        t = 1;
        while (usb_wait !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        n_tests++;
        if (t > SS + 1) begin
            n_fail++;
            $display("FAIL stall_release: usb_wait rose after %0d clk, limit %0d", t, SS + 1);
        end
        chk("stall_bus", usb_db, 8'h7E);
        usb_dstb = 1;
        wait_for(1'b0, "stall_wait_fall");
        @(negedge clk);
`else
        mpush(8'h99);
        aw(8'h00);
        for (int i = 0; i < 17; i++) dw(8'(i + 8'h40));
        aw(8'h02);
        dr_chk("status_ovf_full", 8'h12);
        dr_chk("status_reread", 8'h02);
`endif

        aw(8'h03);
        dw(8'h03);
        aw(8'h00);
        for (int i = 0; i < 5; i++) dw(8'(i + 8'hC0));
        for (int i = 0; i < 5; i++) mpush(8'(i + 8'hD0));
        aw(8'h03);
        usb_write = 0; tb_drv = 1; tb_db = 8'h03;
        repeat (SS + 1) @(negedge clk);
        usb_dstb = 0;
        wait_for(1'b1, "flush_wait_rise");
        usb_dstb = 1;
        repeat (SS) @(negedge clk);
        d_valid = 1; d_data = 8'hEE;
        @(negedge clk);
        d_valid = 0;
        chk("flush_wait_low", {7'b0, usb_wait}, 8'h00);
        @(negedge clk);
        aw(8'h04);
        dr_chk("flush_h2m_count", 8'h00);
        aw(8'h05);
        dr_chk("flush_m2h_count", 8'h00);
        aw(8'h02);
        dr_chk("flush_status", 8'h05);

        for (int i = 0; i < 3; i++) mpush(8'(i + 8'hE0));
        aw(8'h00);
        dw(8'h61); dw(8'h62);
        aw(8'h05);
        usb_write = 1; tb_drv = 0;
        repeat (SS + 1) @(negedge clk);
        usb_dstb = 0;
        wait_for(1'b1, "rst_ack_rise");
        reset = 1;
        usb_dstb = 1;
        @(negedge clk);
        chk("rst_ack_wait", {7'b0, usb_wait}, 8'h00);
        chk("rst_ack_h2m_valid", {7'b0, h2m_valid}, 8'h00);
        chk("rst_ack_m2h_ready", {7'b0, m2h_ready}, 8'h01);
        reset = 0;
        @(negedge clk);
        host(1, 1, 8'h00, v);
        chk("rst_addr", v, 8'h00);
        aw(8'h04);
        dr_chk("rst_h2m_count", 8'h00);
        aw(8'h05);
        dr_chk("rst_m2h_count", 8'h00);

        rand_en = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0:       host(1, 0, 8'($urandom_range(0, 6)), v);
                1, 2:    host(0, 0, 8'($urandom), v);
                3, 4:    host(0, 1, 8'h00, v);
                default: host(1, 1, 8'h00, v);
            endcase
        end
        rand_en = 0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
